// File: rtl/midi_pkg.sv
// Shared MIDI constants: line rate, real-time threshold, receiver states
// and the status nibbles the downstream message processor decodes.
package midi_pkg;

    localparam int MIDI_BAUD = 31250;
    localparam logic [7:0] MIDI_RT_MIN = 8'hF8;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE  = 3'd0;
    localparam rx_state_t ST_START = 3'd1;
    localparam rx_state_t ST_DATA  = 3'd2;
    localparam rx_state_t ST_STOP  = 3'd3;
    localparam rx_state_t ST_BREAK = 3'd4;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] CTRL_CHG = 4'hB;

    function automatic logic is_realtime(input logic [7:0] b);
        return b >= MIDI_RT_MIN;
    endfunction

endpackage

// File: rtl/midi_uart_rx_if.sv
// Byte stream and status strobes from the MIDI receiver to the
// message processor; master is the receiver side.
interface midi_uart_rx_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       framing_error;
    logic       rx_busy;
    logic       rt_dropped;

    modport master (
        output byte_valid,
        output byte_data,
        output framing_error,
        output rx_busy,
        output rt_dropped
    );

    modport slave (
        input byte_valid,
        input byte_data,
        input framing_error,
        input rx_busy,
        input rt_dropped
    );

endinterface

// File: rtl/midi_rx_tick_gen.sv
// Oversample tick divider: counts 0..DIV-1 and pulses tick on the wrap;
// clear holds the count at zero so the bit grid can realign to an edge.
module midi_rx_tick_gen #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = !clear && (cnt_q == W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 receiver: synchronise the opto line, vote mid-bit samples,
// emit one strobe per frame (byte, framing error or dropped real-time).
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int BAUD          = MIDI_BAUD,
    parameter int OVERSAMPLE    = 16,
    parameter int DROP_REALTIME = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           MIDI_RX,
    midi_uart_rx_if.master rx
);

    localparam int TICK_DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = SW + 1;

    localparam logic [SW-1:0] SMP_A   = SW'(7);
    localparam logic [SW-1:0] SMP_B   = SW'(8);
    localparam logic [SW-1:0] SMP_V   = SW'(9);
    localparam logic [SW-1:0] SMP_PRE = SW'(2);

    logic            rx_m_q, rx_s_q, rx_p_q;
    rx_state_t       state_q, state_d;
    logic [SW-1:0]   sample_q, sample_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            s7_q, s7_d, s8_q, s8_d;
    logic [BW-1:0]   brk_q, brk_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rtd_q, rtd_d;
    logic            tick, tick_clr, fall, vote, at_vote, in_frame;

    assign tick_clr = (state_q == ST_IDLE) ||
                      (state_q == ST_BREAK && !rx_s_q);

    midi_rx_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clr),
        .tick  (tick)
    );

    assign fall     = rx_p_q && !rx_s_q;
    assign vote     = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
    assign at_vote  = tick && (sample_q == SMP_V);
    assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_STOP);

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        s7_d     = s7_q;
        s8_d     = s8_q;
        brk_d    = brk_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        rtd_d    = 1'b0;

        if (in_frame && tick) begin
            sample_d = sample_q + 1'b1;
            if (sample_q == SMP_A) s7_d = rx_s_q;
            if (sample_q == SMP_B) s8_d = rx_s_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                // The sync delay puts the edge two samples into the bit,
                // so preloading keeps the vote centred on the bit.
                if (fall) begin
                    state_d  = ST_START;
                    sample_d = SMP_PRE;
                end
            end
            ST_START: begin
                if (at_vote) begin
                    state_d = vote ? ST_IDLE : ST_DATA;
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (at_vote) begin
                    shift_d = {vote, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_vote) begin
                    if (vote) begin
                        state_d = ST_IDLE;
                        if (DROP_REALTIME != 0 && is_realtime(shift_q)) begin
                            rtd_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        brk_d   = '0;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (!rx_s_q)   brk_d = '0;
                else if (tick) brk_d = brk_q + 1'b1;
                if (brk_q == BW'(OVERSAMPLE)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m_q   <= 1'b1;
            rx_s_q   <= 1'b1;
            rx_p_q   <= 1'b1;
            state_q  <= ST_IDLE;
            sample_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            s7_q     <= 1'b1;
            s8_q     <= 1'b1;
            brk_q    <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            rtd_q    <= 1'b0;
        end else begin
            rx_m_q   <= MIDI_RX;
            rx_s_q   <= rx_m_q;
            rx_p_q   <= rx_s_q;
            state_q  <= state_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            s7_q     <= s7_d;
            s8_q     <= s8_d;
            brk_q    <= brk_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            rtd_q    <= rtd_d;
        end
    end

    assign rx.byte_valid    = valid_q;
    assign rx.byte_data     = data_q;
    assign rx.framing_error = ferr_q;
    assign rx.rt_dropped    = rtd_q;
    assign rx.rx_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed plus randomised frames into two receivers (real-time drop on
// and off), checked against a frame-level model of the expected strobes.
module tb_midi_uart_rx;
    import midi_pkg::*;

    localparam int CLK_HZ = 5_000_000;
    localparam int DIV    = CLK_HZ / (MIDI_BAUD * 16);
    localparam int BIT    = DIV * 16;
    localparam int LAT    = BIT * 19 / 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic midi_rx = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   viol = 0;
    int   busy_bad = 0;
    bit   p0 = 0, p1 = 0;
    logic [7:0] last [2];
    ev_t  q0[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_uart_rx_if if0();
    midi_uart_rx_if if1();

    midi_uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(MIDI_BAUD),
                   .OVERSAMPLE(16), .DROP_REALTIME(1)) dut0 (
        .clk(clk), .rst(rst), .MIDI_RX(midi_rx), .rx(if0));

    midi_uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(MIDI_BAUD),
                   .OVERSAMPLE(16), .DROP_REALTIME(0)) dut1 (
        .clk(clk), .rst(rst), .MIDI_RX(midi_rx), .rx(if1));

    always @(negedge clk) begin
        int n0, n1;
        n0 = int'(if0.byte_valid) + int'(if0.framing_error) + int'(if0.rt_dropped);
        n1 = int'(if1.byte_valid) + int'(if1.framing_error) + int'(if1.rt_dropped);
        if (n0 > 1 || (n0 > 0 && p0)) viol++;
        if (n1 > 1 || (n1 > 0 && p1)) viol++;
        p0 = (n0 > 0);
        p1 = (n1 > 0);
        if (if0.byte_valid)    q0.push_back('{1, if0.byte_data, cyc});
        if (if0.framing_error) q0.push_back('{2, if0.byte_data, cyc});
        if (if0.rt_dropped)    q0.push_back('{3, if0.byte_data, cyc});
        if (if1.byte_valid)    q1.push_back('{1, if1.byte_data, cyc});
        if (if1.framing_error) q1.push_back('{2, if1.byte_data, cyc});
        if (if1.rt_dropped)    q1.push_back('{3, if1.byte_data, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 1 = byte delivered, 2 = framing error, 3 = real-time suppressed
    function automatic int exp_kind(input logic [7:0] b, input bit stop_ok,
                                    input bit drop);
        if (!stop_ok) return 2;
        if (drop && b >= 8'hF8) return 3;
        return 1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        midi_rx = 1'b1;
        wait_cyc(n);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_d0"}, {if0.byte_valid, if0.byte_data, if0.framing_error,
                             if0.rx_busy, if0.rt_dropped}, 0);
        check({tag, "_d1"}, {if1.byte_valid, if1.byte_data, if1.framing_error,
                             if1.rx_busy, if1.rt_dropped}, 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input real bt, input int rst_slot);
        logic [9:0] bits;
        int e0, e1, d, h;
        bits = {stop_ok, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            e0 = $rtoi(k * bt + 0.5);
            e1 = $rtoi((k + 1) * bt + 0.5);
            d = e1 - e0;
            h = d / 2;
            midi_rx = bits[k];
            wait_cyc(h);
            if (rst_slot < 0 && k < 9 && (if0.rx_busy !== 1'b1 || if1.rx_busy !== 1'b1))
                busy_bad++;
            if (k == rst_slot) rst = 1'b1;
            wait_cyc(d - h);
        end
        if (rst_slot >= 0) begin
            chk_zero("rst_mid");
            rst = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b,
                               input bit stop_ok);
        for (int d = 0; d < 2; d++) begin
            ev_t q[$];
            int k;
            if (d == 0) q = q0;
            else        q = q1;
            k = exp_kind(b, stop_ok, d == 0);
            check($sformatf("%s_d%0d_n", tag, d), q.size(), 1);
            if (q.size() == 1) begin
                check($sformatf("%s_d%0d_kind", tag, d), q[0].kind, k);
                if (k == 1) begin
                    check($sformatf("%s_d%0d_data", tag, d), q[0].data, b);
                    last[d] = b;
                end else begin
                    check($sformatf("%s_d%0d_hold", tag, d), q[0].data, last[d]);
                end
            end
        end
        q0.delete();
        q1.delete();
    endtask

    initial begin
        int t0, w;
        logic [7:0] rb;
        bit rok;
        real rbt;
        logic [7:0] b2b [3];

        last[0] = 8'h00;
        last[1] = 8'h00;
        b2b[0] = 8'h90;
        b2b[1] = 8'h3C;
        b2b[2] = 8'h64;

        wait_cyc(5);
        chk_zero("reset");
        rst = 1'b0;
        idle(2 * BIT);
        q0.delete();
        q1.delete();

        t0 = cyc;
        busy_bad = 0;
        send_frame(8'h90, 1'b1, real'(BIT), -1);
        idle(BIT);
        check("busy_frame", busy_bad, 0);
        if (q0.size() > 0) begin
            w = q0[0].cyc - t0;
            check("latency", (w >= LAT - 3 && w <= LAT + 3), 1);
        end
        check_frame("b90", 8'h90, 1'b1);

        midi_rx = 1'b0;
        wait_cyc(3 * DIV);
        midi_rx = 1'b1;
        check("glitch_busy", if0.rx_busy, 1'b1);
        w = 3 * DIV;
        while ((if0.rx_busy || if1.rx_busy) && w < 20 * DIV) begin
            wait_cyc(1);
            w++;
        end
        check("glitch_idle", (w <= 9 * DIV), 1);
        idle(2 * BIT);
        check("glitch_n0", q0.size(), 0);
        check("glitch_n1", q1.size(), 0);

        for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1, real'(BIT), -1);
        idle(BIT);
        check("b2b_n", q1.size(), 3);
        if (q1.size() == 3) begin
            check("b2b_gap", q1[1].cyc - q1[0].cyc, 10 * BIT);
            for (int i = 0; i < 3; i++)
                check($sformatf("b2b_data%0d", i), q1[i].data, b2b[i]);
            last[0] = 8'h64;
            last[1] = 8'h64;
        end
        q0.delete();
        q1.delete();

        send_frame(8'h55, 1'b0, real'(BIT), -1);
        wait_cyc(5 * BIT);
        idle(2 * BIT);
        check_frame("ferr", 8'h55, 1'b0);
        send_frame(8'h80, 1'b1, real'(BIT), -1);
        idle(BIT);
        check_frame("after_brk", 8'h80, 1'b1);

        send_frame(8'h3C, 1'b1, real'(BIT), -1);
        idle(BIT);
        check_frame("b3c", 8'h3C, 1'b1);
        send_frame(8'hF8, 1'b1, real'(BIT), -1);
        idle(BIT);
        check_frame("rt_f8", 8'hF8, 1'b1);

        send_frame(8'hB0, 1'b1, real'(BIT), 5);
        idle(2 * BIT);
        check("rst_n0", q0.size(), 0);
        check("rst_n1", q1.size(), 0);
        last[0] = 8'h00;
        last[1] = 8'h00;
        send_frame(8'h01, 1'b1, real'(BIT), -1);
        idle(BIT);
        check_frame("post_rst", 8'h01, 1'b1);

        send_frame(8'hA5, 1'b1, BIT * 1.03, -1);
        idle(BIT);
        check_frame("slow_a5", 8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1, BIT * 0.97, -1);
        idle(BIT);
        check_frame("fast_a5", 8'hA5, 1'b1);

        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 8'hF8 + 8'($urandom_range(0, 7));
            rok = ($urandom_range(0, 5) != 0);
            rbt = BIT * (0.97 + $urandom_range(0, 60) / 1000.0);
            send_frame(rb, rok, rbt, -1);
            idle(2 * BIT + $urandom_range(0, BIT));
            check_frame($sformatf("rnd%0d", i), rb, rok);
        end

        check("busy_all", busy_bad, 0);
        check("strobe_excl", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
